// File: rtl/aes_channel_arbiter.sv
// rtl/aes_channel_arbiter.sv - round-robin arbiter sharing one aes_encryptor among NUM_CH channels
module aes_channel_arbiter #(
    parameter int NUM_CH         = 4,
    parameter int DATA_W         = 128,
    parameter int EMPTY_W        = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int CH_W          = $clog2(NUM_CH),
    localparam int WD_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CH-1:0]           ch_key_valid,
    output logic [NUM_CH-1:0]           ch_key_rdy,
    input  logic [NUM_CH*DATA_W-1:0]    ch_key,
    input  logic [NUM_CH*DATA_W-1:0]    ch_sync,
    input  logic [NUM_CH-1:0]           ch_in_valid,
    output logic [NUM_CH-1:0]           ch_in_rdy,
    input  logic [NUM_CH*DATA_W-1:0]    ch_in_data,
    input  logic [NUM_CH-1:0]           ch_in_sop,
    input  logic [NUM_CH-1:0]           ch_in_eop,
    input  logic [NUM_CH*EMPTY_W-1:0]   ch_in_empty,
    output logic                        enc_key_valid,
    input  logic                        enc_key_rdy,
    output logic [DATA_W-1:0]           enc_key,
    output logic [DATA_W-1:0]           enc_sync,
    output logic                        enc_in_valid,
    input  logic                        enc_in_rdy,
    output logic [DATA_W-1:0]           enc_in_data,
    output logic                        enc_in_sop,
    output logic                        enc_in_eop,
    output logic [EMPTY_W-1:0]          enc_in_empty,
    input  logic                        enc_out_valid,
    input  logic                        enc_out_rdy,
    input  logic                        enc_out_eop,
    output logic [CH_W-1:0]             active_ch,
    output logic                        busy,
    output logic                        timeout
);

    typedef enum logic [1:0] {IDLE, LOAD_KEY, STREAM, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [CH_W-1:0] grant_q, grant_d;
    logic [CH_W-1:0] last_grant_q, last_grant_d;
    logic [WD_W-1:0] wdog_q, wdog_d;

    logic            rr_found;
    logic [CH_W-1:0] rr_pick;
    logic [CH_W-1:0] rr_cand;
    logic            in_hs, in_eop_hs, out_hs, out_eop_hs;

    // Search starts just above the last winner so it gets lowest priority.
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = '0;
        rr_cand  = '0;
        for (int off = 1; off <= NUM_CH; off++) begin
            rr_cand = CH_W'((int'(last_grant_q) + off) % NUM_CH);
            if (!rr_found && ch_key_valid[rr_cand]) begin
                rr_found = 1'b1;
                rr_pick  = rr_cand;
            end
        end
    end

    assign in_hs      = (state_q == STREAM) && ch_in_valid[grant_q] && enc_in_rdy;
    assign in_eop_hs  = in_hs && ch_in_eop[grant_q];
    assign out_hs     = enc_out_valid && enc_out_rdy;
    assign out_eop_hs = out_hs && enc_out_eop;

    assign enc_key   = ch_key[int'(grant_q)*DATA_W +: DATA_W];
    assign enc_sync  = ch_sync[int'(grant_q)*DATA_W +: DATA_W];
    assign active_ch = grant_q;
    assign busy      = (state_q != IDLE);

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        wdog_d        = '0;
        enc_key_valid = 1'b0;
        ch_key_rdy    = '0;
        enc_in_valid  = 1'b0;
        enc_in_data   = '0;
        enc_in_sop    = 1'b0;
        enc_in_eop    = 1'b0;
        enc_in_empty  = '0;
        ch_in_rdy     = '0;
        timeout       = 1'b0;

        case (state_q)
            IDLE: begin
                if (rr_found) begin
                    grant_d = rr_pick;
                    state_d = LOAD_KEY;
                end
            end
            LOAD_KEY: begin
                enc_key_valid       = ch_key_valid[grant_q];
                ch_key_rdy[grant_q] = enc_key_rdy;
                if (ch_key_valid[grant_q] && enc_key_rdy) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                enc_in_valid       = ch_in_valid[grant_q];
                enc_in_data        = ch_in_data[int'(grant_q)*DATA_W +: DATA_W];
                enc_in_sop         = ch_in_sop[grant_q];
                enc_in_eop         = ch_in_eop[grant_q];
                enc_in_empty       = ch_in_empty[int'(grant_q)*EMPTY_W +: EMPTY_W];
                ch_in_rdy[grant_q] = enc_in_rdy;
                if (in_eop_hs) begin
                    state_d = out_eop_hs ? IDLE : DRAIN;
                end
            end
            DRAIN: begin
                if (out_eop_hs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Watchdog only runs while a packet is in flight; it is zero on STREAM entry.
        if (state_q == STREAM || state_q == DRAIN) begin
            if (in_hs || out_hs) begin
                wdog_d = '0;
            end else if (wdog_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                timeout = 1'b1;
                state_d = IDLE;
            end else begin
                wdog_d = wdog_q + 1'b1;
            end
            if (state_d == IDLE) begin
                last_grant_d = grant_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= CH_W'(NUM_CH - 1);
            wdog_q       <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            wdog_q       <= wdog_d;
        end
    end

endmodule

// File: tb/tb_aes_channel_arbiter.sv
// tb/tb_aes_channel_arbiter.sv - self-checking bench for aes_channel_arbiter
module tb_aes_channel_arbiter;
    localparam int N  = 4;
    localparam int DW = 128;
    localparam int EW = 4;
    localparam int TO = 16;
    localparam logic [DW-1:0] FOREIGN = {8{16'hDEAD}};

    logic clk = 1'b0;
    logic rst;
    logic [N-1:0]    ch_key_valid, ch_key_rdy;
    logic [N*DW-1:0] ch_key, ch_sync;
    logic [N-1:0]    ch_in_valid, ch_in_rdy, ch_in_sop, ch_in_eop;
    logic [N*DW-1:0] ch_in_data;
    logic [N*EW-1:0] ch_in_empty;
    logic            enc_key_valid, enc_key_rdy;
    logic [DW-1:0]   enc_key, enc_sync;
    logic            enc_in_valid, enc_in_rdy;
    logic [DW-1:0]   enc_in_data;
    logic            enc_in_sop, enc_in_eop;
    logic [EW-1:0]   enc_in_empty;
    logic            enc_out_valid, enc_out_rdy, enc_out_eop;
    logic [1:0]      active_ch;
    logic            busy, timeout;

    int n_cmp = 0;
    int n_bad = 0;
    int last_m;

    typedef struct {
        logic [N-1:0] mask;
        int           exp_ch;
        int           nb;
        int           stall;
    } vec_t;
    vec_t tbl[12];

    always #5 clk = ~clk;

    aes_channel_arbiter #(
        .NUM_CH(N), .DATA_W(DW), .EMPTY_W(EW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .ch_key_valid(ch_key_valid), .ch_key_rdy(ch_key_rdy),
        .ch_key(ch_key), .ch_sync(ch_sync),
        .ch_in_valid(ch_in_valid), .ch_in_rdy(ch_in_rdy),
        .ch_in_data(ch_in_data), .ch_in_sop(ch_in_sop),
        .ch_in_eop(ch_in_eop), .ch_in_empty(ch_in_empty),
        .enc_key_valid(enc_key_valid), .enc_key_rdy(enc_key_rdy),
        .enc_key(enc_key), .enc_sync(enc_sync),
        .enc_in_valid(enc_in_valid), .enc_in_rdy(enc_in_rdy),
        .enc_in_data(enc_in_data), .enc_in_sop(enc_in_sop),
        .enc_in_eop(enc_in_eop), .enc_in_empty(enc_in_empty),
        .enc_out_valid(enc_out_valid), .enc_out_rdy(enc_out_rdy),
        .enc_out_eop(enc_out_eop),
        .active_ch(active_ch), .busy(busy), .timeout(timeout)
    );

    function automatic logic [DW-1:0] key_of(input int ch);
        return {32'hC0DE_0000 + 32'(ch), 96'h1234_5678_9ABC_DEF0_1122_3344};
    endfunction

    function automatic logic [DW-1:0] sync_of(input int ch);
        return {96'h5EED_0000_A5A5_5A5A_0F0F_F0F0, 32'h0000_0100 + 32'(ch)};
    endfunction

    // Reference: walk the channels in rotation order after the last winner.
    function automatic int model_pick(input int last, input logic [N-1:0] mask);
        int order[$];
        for (int k = 1; k <= N; k++) order.push_back((last + k) % N);
        foreach (order[j]) if (mask[order[j]]) return order[j];
        return -1;
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic arb_and_load(input logic [N-1:0] mask, input int exp_ch, input int stall);
        int waited = 0;
        ch_key_valid = mask;
        enc_key_rdy  = 1'b0;
        @(negedge clk); #1;
        while (!busy && waited < 10) begin
            waited++;
            @(negedge clk); #1;
        end
        chk("arb_latency", waited, 0);
        chk("active_ch", active_ch, exp_ch);
        chk("enc_key", enc_key, key_of(exp_ch));
        chk("enc_sync", enc_sync, sync_of(exp_ch));
        for (int k = 0; k < stall; k++) begin
            chk("key_valid_stall", enc_key_valid, 1);
            chk("key_rdy_stall", ch_key_rdy, 0);
            chk("load_hold", {busy, active_ch}, {1'b1, 2'(exp_ch)});
            @(negedge clk); #1;
        end
        enc_key_rdy = 1'b1;
        #1;
        chk("key_valid", enc_key_valid, 1);
        chk("key_rdy_grant", ch_key_rdy, N'(1) << exp_ch);
        @(negedge clk);
        enc_key_rdy  = 1'b0;
        ch_key_valid = '0;
    endtask

    task automatic stream(input int ch, input int nbeats, input int stop_after,
                          input bit fast, input bit same_eop);
        int b = 0;
        int guard = 0;
        logic [DW-1:0] d;
        logic [EW-1:0] e;
        bit lastb;
        while (b < nbeats && b != stop_after && guard < 200) begin
            guard++;
            d = {$urandom, $urandom, $urandom, $urandom};
            e = EW'($urandom);
            lastb = (b == nbeats - 1);
            ch_in_valid = '1;
            for (int i = 0; i < N; i++) begin
                ch_in_data[i*DW +: DW]  = (i == ch) ? d : FOREIGN;
                ch_in_empty[i*EW +: EW] = (i == ch) ? e : '1;
            end
            ch_in_sop  = (b == 0) ? (N'(1) << ch) : '0;
            ch_in_eop  = lastb ? (N'(1) << ch) : '0;
            enc_in_rdy = fast || ($urandom_range(0, 3) != 0);
            if (same_eop && lastb) begin
                enc_in_rdy    = 1'b1;
                enc_out_valid = 1'b1;
                enc_out_rdy   = 1'b1;
                enc_out_eop   = 1'b1;
            end
            #1;
            chk("in_valid", enc_in_valid, 1);
            chk("in_data", enc_in_data, d);
            chk("in_sop_eop", {enc_in_sop, enc_in_eop}, {b == 0, lastb});
            chk("in_empty", enc_in_empty, e);
            chk("in_rdy_iso", ch_in_rdy, N'(enc_in_rdy) << ch);
            if (enc_in_rdy) b++;
            @(negedge clk);
        end
        if (guard >= 200) chk("stream_guard", 0, 1);
        enc_out_valid = 1'b0;
        enc_out_rdy   = 1'b0;
        enc_out_eop   = 1'b0;
        ch_in_sop     = '0;
        ch_in_eop     = '0;
    endtask

    task automatic drain(input int delay);
        for (int k = 0; k < delay; k++) begin
            #1;
            chk("drain_in_valid", enc_in_valid, 0);
            chk("drain_in_rdy", ch_in_rdy, 0);
            chk("drain_busy", busy, 1);
            @(negedge clk);
        end
        enc_out_valid = 1'b1;
        enc_out_rdy   = 1'b1;
        enc_out_eop   = 1'b1;
        @(negedge clk);
        enc_out_valid = 1'b0;
        enc_out_rdy   = 1'b0;
        enc_out_eop   = 1'b0;
        #1;
        chk("idle_after_eop", busy, 0);
    endtask

    task automatic txn(input logic [N-1:0] mask, input int exp_ch, input int nb,
                       input int stall, input int ddelay, input bit same_eop);
        arb_and_load(mask, exp_ch, stall);
        stream(exp_ch, nb, -1, 1'b0, same_eop);
        if (same_eop) begin
            #1;
            chk("same_cycle_idle", busy, 0);
        end else begin
            drain(ddelay);
        end
        last_m = exp_ch;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{4'b1011, 0, 1, 0};
        tbl[1]  = '{4'b1011, 1, 2, 0};
        tbl[2]  = '{4'b1011, 3, 1, 0};
        tbl[3]  = '{4'b0011, 0, 1, 0};
        tbl[4]  = '{4'b0011, 1, 2, 0};
        tbl[5]  = '{4'b0011, 0, 1, 0};
        tbl[6]  = '{4'b0011, 1, 1, 0};
        tbl[7]  = '{4'b0100, 2, 3, 0};
        tbl[8]  = '{4'b1000, 3, 2, 5};
        tbl[9]  = '{4'b1111, 0, 1, 0};
        tbl[10] = '{4'b1001, 3, 1, 0};
        tbl[11] = '{4'b1001, 0, 4, 2};

        rst = 1'b1;
        ch_key_valid = '0; enc_key_rdy = 1'b0;
        ch_in_valid = '1; ch_in_sop = '0; ch_in_eop = '0;
        ch_in_data = '0; ch_in_empty = '0;
        enc_in_rdy = 1'b0; enc_out_valid = 1'b0; enc_out_rdy = 1'b0; enc_out_eop = 1'b0;
        for (int i = 0; i < N; i++) begin
            ch_key[i*DW +: DW]  = key_of(i);
            ch_sync[i*DW +: DW] = sync_of(i);
        end
        last_m = N - 1;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_active_ch", active_ch, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_valids", {enc_key_valid, enc_in_valid}, 0);
        chk("rst_rdys", {ch_key_rdy, ch_in_rdy}, 0);
        chk("rst_in_data", enc_in_data, 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            txn(tbl[i].mask, tbl[i].exp_ch, tbl[i].nb, tbl[i].stall, i % 3, 1'b0);
        end

        txn(4'b0010, model_pick(last_m, 4'b0010), 2, 0, 0, 1'b1);

        // Encrypted eop never accepted: watchdog must abort the DRAIN.
        arb_and_load(4'b0010, 1, 0);
        stream(1, 1, -1, 1'b1, 1'b0);
        enc_out_valid = 1'b1;
        enc_out_eop   = 1'b1;
        enc_out_rdy   = 1'b0;
        for (int k = 1; k <= TO; k++) begin
            #1;
            chk("wd_timeout", timeout, k == TO);
            chk("wd_busy", busy, 1);
            @(negedge clk);
        end
        enc_out_valid = 1'b0;
        enc_out_eop   = 1'b0;
        #1;
        chk("wd_busy_fall", busy, 0);
        chk("wd_pulse_end", timeout, 0);
        last_m = 1;
        txn(4'b0101, 2, 2, 0, 1, 1'b0);

        // Asynchronous reset in the middle of a 4-beat packet.
        arb_and_load(4'b0100, model_pick(last_m, 4'b0100), 0);
        stream(2, 4, 2, 1'b1, 1'b0);
        #1;
        chk("pre_rst_valid", enc_in_valid, 1);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_valid", enc_in_valid, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_rdys", {ch_key_rdy, ch_in_rdy}, 0);
        @(negedge clk);
        rst = 1'b0;
        last_m = N - 1;
        txn(4'b1111, 0, 2, 0, 1, 1'b0);

        for (int t = 0; t < 40; t++) begin
            logic [N-1:0] m;
            m = N'($urandom_range(1, (1 << N) - 1));
            txn(m, model_pick(last_m, m), $urandom_range(1, 4), $urandom_range(0, 3),
                $urandom_range(0, 5), $urandom_range(0, 7) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
